mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multi-cycle RV32I main control FSM. Sits between instruction register and datapath.
//  Decodes op/funct fields, sequences FETCH..WRITEBACK, drives datapath mux selects and enables.
//  Drives immsrc[2:0], which feeds the immediate extender. Resolves BEQ with ALU zero flag.
// PARAMETERS
//  (none; encodings live in riscv_ctrl_pkg)
// PORTS
//  clk        in  1  system clock, rising edge
//  rst_n      in  1  asynchronous active-low reset
//  op         in  7  instr[6:0] from instruction register
//  funct3     in  3  instr[14:12]
//  funct7b5   in  1  instr[30]
//  zero       in  1  ALU result == 0
//  pcwrite    out 1  PC load enable
//  adrsrc     out 1  memory address select: 0=PC, 1=ALUOut
//  memwrite   out 1  data memory write enable
//  irwrite    out 1  instruction register / OldPC load enable
//  regwrite   out 1  register file write enable
//  resultsrc  out 2  00=ALUOut, 01=Data, 10=ALUResult
//  alusrca    out 2  00=PC, 01=OldPC, 10=rs1, 11=zero
//  alusrcb    out 2  00=rs2, 01=ImmExt, 10=const 4
//  alucontrol out 3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  immsrc     out 3  000 I, 001 S, 010 B, 011 J, 100 U
//  illegal    out 1  sticky illegal-opcode flag (only with ILLEGAL_TRAP_EN)
// BEHAVIOUR
//  - Moore FSM; state register updates on posedge clk. rst_n low -> state=RESET immediately.
//  - RESET: all outputs 0 (immsrc/alucontrol 000, illegal 0); next state FETCH unconditionally.
//  - FETCH: irwrite=1, adrsrc=0, alusrca=00, alusrcb=10, add, resultsrc=10, pcwrite=1 -> DECODE.
//  - DECODE: alusrca=01, alusrcb=01, add (branch target into ALUOut). Next by op:
//    0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ,
//    1101111 -> JAL, 0110111 -> LUI, other -> see CONFIGURATION.
//  - MEMADR: alusrca=10, alusrcb=01, add; op[5]=0 -> MEMREAD, 1 -> MEMWRITE.
//  - MEMREAD: adrsrc=1, resultsrc=00 -> MEMWB. MEMWB: resultsrc=01, regwrite=1 -> FETCH.
//  - MEMWRITE: adrsrc=1, memwrite=1 -> FETCH.
//  - EXECR: alusrca=10, alusrcb=00, ALU op from funct -> ALUWB. EXECI: same, alusrcb=01.
//  - LUI: alusrca=11, alusrcb=01, add -> ALUWB. ALUWB: resultsrc=00, regwrite=1 -> FETCH.
//  - BEQ: alusrca=10, alusrcb=00, sub, resultsrc=00; pcwrite=zero -> FETCH.
//  - JAL: alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite=1 -> ALUWB.
//  - Cycles/instr: lw 5, sw 4, R 4, I 4, lui 4, jal 4, beq 3.
//  - immsrc: combinational from op, valid every state (extender runs in DECODE):
//    lw/I-ALU 000, sw 001, beq 010, jal 011, lui 100, other 000.
//  - alucontrol (non-add/sub-forced states): funct3 000 -> sub iff op[5]&funct7b5 else add;
//    010 slt; 110 or; 111 and; other funct3 -> add.
//  - Enables (pcwrite, memwrite, irwrite, regwrite) never asserted in the same cycle as rst_n low.
//  - Reset mid-instruction: instruction abandoned, no write enable asserted, restarts at FETCH.
// CONFIGURATION
//  - Macro ILLEGAL_TRAP_EN defined: unknown op in DECODE -> TRAP; TRAP holds forever, all enables 0,
//    illegal=1 (sticky until rst_n).
//  - Not defined: unknown op in DECODE -> FETCH (executes as NOP, PC already +4); illegal tied 0.
// STRUCTURE
//  - riscv_ctrl_pkg: state enum (RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
//    EXECR, EXECI, LUI, ALUWB, BEQ, JAL, TRAP), opcode constants, immsrc/alucontrol/mux encodings.
//  - Sub-module alu_decoder: combinational {aluop, funct3, funct7b5, op[5]} -> alucontrol.
// TESTING
//  - Reset: rst_n=0 mid-MEMWRITE -> memwrite drops at once; 1 cycle RESET, then FETCH irwrite=1.
//  - lw 0x0002a303: FETCH,DECODE,MEMADR,MEMREAD,MEMWB; immsrc=000; regwrite only in MEMWB.
//  - sw 0x0062a223: 4 cycles, immsrc=001, memwrite=1 only in MEMWRITE with adrsrc=1.
//  - beq 0x00628463: zero=1 -> pcwrite=1 in BEQ; zero=0 -> pcwrite=0; immsrc=010, alucontrol=001.
//  - jal 0x008000ef -> immsrc=011, JAL pcwrite=1, ALUWB; lui 0x000003b7 -> immsrc=100, alusrca=11.
//  - R-type sub 0x40628333 -> alucontrol=001 in EXECR; op 0x7f: TRAP+illegal=1 (with EN), else FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg : state, opcode and datapath-select encodings for mc_controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_LUI      = 4'd9,
    S_ALUWB    = 4'd10,
    S_BEQ      = 4'd11,
    S_JAL      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // aluop selects between forced add/sub and funct-field decoding
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder : maps {aluop, funct3, funct7b5, op[5]} to alucontrol
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        case (funct3)
          // only R-type (op[5]=1) can encode sub; addi with instr[30] set stays add
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller : multi-cycle RV32I main control FSM (Moore).
// Optional macro ILLEGAL_TRAP_EN: unknown opcode traps with sticky illegal flag.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [2:0] immsrc,
  output logic       illegal
);

  state_t     state, state_next;
  logic [1:0] aluop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pcwrite    = 1'b0;
    adrsrc     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    resultsrc  = RES_ALUOUT;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_RS2;
    aluop      = ALUOP_ADD;
    illegal    = 1'b0;
    case (state)
      S_RESET: state_next = S_FETCH;
      S_FETCH: begin
        irwrite    = 1'b1;
        alusrcb    = SRCB_FOUR;
        resultsrc  = RES_ALURES;
        pcwrite    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          OP_LUI:            state_next = S_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:           state_next = S_TRAP;
`else
          default:           state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc     = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc  = RES_DATA;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECR: begin
        alusrca    = SRCA_RS1;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        alusrca    = SRCA_ZERO;
        alusrcb    = SRCB_IMM;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alusrca    = SRCA_RS1;
        aluop      = ALUOP_SUB;
        pcwrite    = zero;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alusrca    = SRCA_OLDPC;
        alusrcb    = SRCB_FOUR;
        pcwrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_TRAP: begin
        state_next = S_TRAP;
`ifdef ILLEGAL_TRAP_EN
        illegal    = 1'b1;
`endif
      end
      default: state_next = S_RESET;
    endcase
  end

  // immsrc follows op in every state so the extender is ready during DECODE
  always_comb begin
    immsrc = IMM_I;
    case (op)
      OP_STORE:  immsrc = IMM_S;
      OP_BRANCH: immsrc = IMM_B;
      OP_JAL:    immsrc = IMM_J;
      OP_LUI:    immsrc = IMM_U;
      default:   immsrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (alucontrol)
  );

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_controller : directed scoreboard bench for mc_controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb;
  logic [2:0] alucontrol, immsrc;

  logic [17:0] obs;
  logic [17:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  mc_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .pcwrite    (pcwrite),
    .adrsrc     (adrsrc),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .immsrc     (immsrc),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  assign obs = {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
                alusrca, alusrcb, alucontrol, immsrc, illegal};

  function automatic logic [17:0] ev(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sbv,
                                     input logic [2:0] ac, input logic [2:0] imm,
                                     input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sbv, ac, imm, ill};
  endfunction

  task automatic issue(input logic [31:0] instr, input logic z);
    op       = instr[6:0];
    funct3   = instr[14:12];
    funct7b5 = instr[30];
    zero     = z;
  endtask

  task automatic push_fd(input logic [2:0] imm);
    sb.push_back(ev(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0));
    sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0));
  endtask

  // compare current outputs against the oldest expected vector
  task automatic check_now(input string tag);
    logic [17:0] e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic check_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_now(tag);
    end
  endtask

  // R/I-type ALU instruction: FETCH, DECODE, EXEC, ALUWB
  task automatic run_alu(input string tag, input logic [31:0] instr, input logic [2:0] ac);
    issue(instr, 1'b0);
    push_fd(3'b000);
    sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, instr[5] ? 2'b00 : 2'b01, ac, 3'b000, 0));
    sb.push_back(ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    check_cycles(tag, 4);
  endtask

  initial begin
    rst_n = 1'b0;
    issue(32'h0, 1'b0);
    repeat (2) @(negedge clk);
    sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    check_now("reset_hold");
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    check_cycles("reset_state", 1);

    // lw
    issue(32'h0002a303, 1'b0);
    push_fd(3'b000);
    sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
    sb.push_back(ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    sb.push_back(ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    check_cycles("lw", 5);

    // sw
    issue(32'h0062a223, 1'b0);
    push_fd(3'b001);
    sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0));
    sb.push_back(ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));
    check_cycles("sw", 4);

    // beq taken / not taken
    issue(32'h00628463, 1'b1);
    push_fd(3'b010);
    sb.push_back(ev(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0));
    check_cycles("beq_taken", 3);
    issue(32'h00628463, 1'b0);
    push_fd(3'b010);
    sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0));
    check_cycles("beq_not_taken", 3);

    // jal
    issue(32'h008000ef, 1'b0);
    push_fd(3'b011);
    sb.push_back(ev(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 0));
    sb.push_back(ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b011, 0));
    check_cycles("jal", 4);

    // lui
    issue(32'h000003b7, 1'b0);
    push_fd(3'b100);
    sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b000, 3'b100, 0));
    sb.push_back(ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b100, 0));
    check_cycles("lui", 4);

    // ALU decode coverage
    run_alu("r_sub",  32'h40628333, 3'b001);
    run_alu("r_add",  32'h00628333, 3'b000);
    run_alu("r_and",  32'h0062f333, 3'b010);
    run_alu("r_slt",  32'h0062a333, 3'b101);
    run_alu("r_sll",  32'h00629333, 3'b000);
    run_alu("i_ori",  32'h0062e313, 3'b011);
    run_alu("i_b30",  32'h40028313, 3'b000);

    // reset asserted in the middle of MEMWRITE
    issue(32'h0062a223, 1'b0);
    push_fd(3'b001);
    sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0));
    check_cycles("sw_pre_reset", 3);
    @(posedge clk);
    #1;
    sb.push_back(ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));
    check_now("sw_memwrite");
    rst_n = 1'b0;
    #1;
    sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0));
    check_now("async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(32'h0002a303, 1'b0);
    sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    check_cycles("reset_cycle", 1);
    push_fd(3'b000);
    check_cycles("refetch", 2);
    sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
    sb.push_back(ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    sb.push_back(ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    check_cycles("lw_after_reset", 3);

    // unknown opcode
    issue(32'h0000007f, 1'b0);
    push_fd(3'b000);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++)
      sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1));
    check_cycles("illegal_trap", 5);
    rst_n = 1'b0;
    #1;
    sb.push_back(ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    check_now("trap_clear");
    @(posedge clk);
    #1 rst_n = 1'b1;
`else
    push_fd(3'b000);
    check_cycles("illegal_nop", 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
